// File: rtl/song_selector_if.sv
// Song selector bus: system mode and raw keys in, selection state and strobes out.
`timescale 1ns/1ps
interface song_selector_if #(
  parameter int IDX_W = 5
);
  logic [1:0]       state;
  logic [2:0]       keys;
  logic [IDX_W-1:0] song_idx;
  logic             selected;
  logic             confirm_pulse;
  logic             changed;

  // Driver side: owns mode and keys, observes the selector.
  modport master (
    output state, keys,
    input  song_idx, selected, confirm_pulse, changed
  );

  // Selector side.
  modport slave (
    input  state, keys,
    output song_idx, selected, confirm_pulse, changed
  );
endinterface

// File: rtl/song_selector.sv
// Song selector: synchronized and debounced up/down/confirm keys drive a
// wrapping song index with auto-repeat on held navigation keys. A locking
// system mode (play or UART) freezes the index and clears all key state.
`timescale 1ns/1ps
module song_selector #(
  parameter int         NUM_SONGS       = 8,
  parameter int         IDX_W           = 5,
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         REPEAT_DELAY    = 16,
  parameter int         REPEAT_PERIOD   = 4,
  parameter logic [1:0] PLAY_MODE       = 2'd1,
  parameter logic [1:0] UART_MODE       = 2'd2
) (
  input logic           clk,
  input logic           rst,
  song_selector_if.slave bus
);

  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   DB_LOAD    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_LOAD = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PER_LOAD   = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SONGS - 1);

  logic                   locked;
  logic [2:0]             sync1_q, sync2_q;
  logic [2:0]             acc_q, acc_prev_q;
  logic [2:0][DB_W-1:0]   db_cnt_q;
  logic [1:0][HOLD_W-1:0] hold_q;
  logic [2:0]             press;
  logic [1:0]             rep;
  logic                   up_step, dn_step, conf_ev;

  logic [IDX_W-1:0] song_idx_q, song_idx_d;
  logic             selected_q, selected_d;
  logic             confirm_q, confirm_d;
  logic             changed_q, changed_d;

  assign locked = (bus.state == PLAY_MODE) || (bus.state == UART_MODE);

  // Synchronizers and debouncers; a mismatch must persist for the full
  // down-count before the accepted level flips, any agreement reloads it.
  always_ff @(posedge clk) begin
    if (rst || locked) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= DB_LOAD;
    end else begin
      sync1_q    <= bus.keys;
      sync2_q    <= sync1_q;
      acc_prev_q <= acc_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          db_cnt_q[i] <= DB_LOAD;
        end else if (db_cnt_q[i] == '0) begin
          acc_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= DB_LOAD;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] - 1'b1;
        end
      end
    end
  end

  assign press = acc_q & ~acc_prev_q;

  // Hold timers for up/down: loaded with the initial delay at the press,
  // reloaded with the period on each repeat, parked while released.
  always_ff @(posedge clk) begin
    if (rst || locked) begin
      for (int i = 0; i < 2; i++) hold_q[i] <= DELAY_LOAD;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!acc_q[i] || press[i]) hold_q[i] <= DELAY_LOAD;
        else if (hold_q[i] == '0)  hold_q[i] <= PER_LOAD;
        else                       hold_q[i] <= hold_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) rep[i] = acc_q[i] && !press[i] && (hold_q[i] == '0);
  end

  assign up_step = press[0] | rep[0];
  assign dn_step = press[1] | rep[1];
  assign conf_ev = press[2];

  // Index and selection update; opposing steps cancel, any step discards confirm.
  always_comb begin
    song_idx_d = song_idx_q;
    selected_d = selected_q;
    confirm_d  = 1'b0;
    changed_d  = 1'b0;
    if (locked) begin
      selected_d = 1'b0;
    end else if (up_step && !dn_step) begin
      song_idx_d = (song_idx_q == LAST_IDX) ? '0 : song_idx_q + 1'b1;
      selected_d = 1'b0;
      changed_d  = 1'b1;
    end else if (dn_step && !up_step) begin
      song_idx_d = (song_idx_q == '0) ? LAST_IDX : song_idx_q - 1'b1;
      selected_d = 1'b0;
      changed_d  = 1'b1;
    end else if (conf_ev && !up_step && !dn_step) begin
      selected_d = 1'b1;
      confirm_d  = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      song_idx_q <= '0;
      selected_q <= 1'b0;
      confirm_q  <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      song_idx_q <= song_idx_d;
      selected_q <= selected_d;
      confirm_q  <= confirm_d;
      changed_q  <= changed_d;
    end
  end

  assign bus.song_idx      = song_idx_q;
  assign bus.selected      = selected_q;
  assign bus.confirm_pulse = confirm_q;
  assign bus.changed       = changed_q;

endmodule

// File: doc/song_selector.md
SONG_SELECTOR -- requirements
Module: song_selector

Interface
REQ-001 Parameter NUM_SONGS, default 8, number of selectable songs, SHALL be >= 2.
REQ-002 Parameter IDX_W, default 5, width of song index, SHALL satisfy 2^IDX_W >= NUM_SONGS.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed to accept a key level, SHALL be >= 1.
REQ-004 Parameter REPEAT_DELAY, default 16, cycles a navigation key is held before the first auto-repeat step.
REQ-005 Parameter REPEAT_PERIOD, default 4, cycles between later auto-repeat steps.
REQ-006 Parameter PLAY_MODE, default 2'd1; UART_MODE, default 2'd2; mode encodings that lock the selector.
REQ-007 Reset and clock: single clock, synchronous active-high reset; clk input 1 is the sole clock; rst input 1 is the synchronous active-high reset.
REQ-008 state input 2: system mode.
REQ-009 keys input 3: raw buttons; [0] up (next), [1] down (previous), [2] confirm.
REQ-010 song_idx output IDX_W: registered current song index.
REQ-011 selected output 1: level, high while the current index is confirmed.
REQ-012 confirm_pulse output 1: one-cycle strobe on each accepted confirm.
REQ-013 changed output 1: one-cycle strobe on each song_idx change.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer, then a per-key debouncer.
REQ-015 Debouncer: the accepted level SHALL take the synchronized level only after it differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any glitch SHALL restart the count.
REQ-016 A press event SHALL be a 0->1 transition of the accepted level; releases SHALL produce no event.
REQ-017 Latency: a raw key rising and held stable from cycle 0 SHALL update song_idx/selected/strobes at cycle 2+DEBOUNCE_CYCLES+1.
REQ-018 Up event: song_idx SHALL increment; NUM_SONGS-1 SHALL wrap to 0.
REQ-019 Down event: song_idx SHALL decrement; 0 SHALL wrap to NUM_SONGS-1.
REQ-020 Index arithmetic SHALL be modulo NUM_SONGS; song_idx SHALL never exceed NUM_SONGS-1.
REQ-021 Any index change SHALL clear selected and assert changed for exactly that cycle.
REQ-022 Confirm event with no navigation step in the same cycle SHALL set selected and assert confirm_pulse for one cycle, including when selected is already 1.
REQ-023 Up and down steps in the same cycle SHALL cancel: no index change, no changed strobe.
REQ-024 A navigation step coinciding with a confirm event SHALL take priority: the step applies, the confirm is discarded, and selected ends at 0.
REQ-025 Auto-repeat: per navigation key, a hold counter SHALL start at the press event; while the accepted level stays 1, an extra step SHALL occur REPEAT_DELAY cycles after the press and every REPEAT_PERIOD cycles thereafter.
REQ-026 Each auto-repeat step SHALL behave exactly as a press step (wrap, clear selected, changed strobe).
REQ-027 Confirm SHALL NOT auto-repeat.
REQ-028 Release of the accepted level SHALL stop repeat immediately and clear the hold counter.
REQ-029 Lock: while state == PLAY_MODE or UART_MODE, debouncers, edge detectors and hold counters SHALL be held cleared.
REQ-030 During lock, selected SHALL be 0, confirm_pulse and changed SHALL be 0, and song_idx SHALL hold its value.
REQ-031 On leaving lock, a key already held SHALL be treated as a fresh press after the full synchronizer+debounce latency.

Reset
REQ-032 While rst=1 at a clk edge: song_idx=0, selected=0, confirm_pulse=0, changed=0; synchronizers, debouncers and hold counters cleared.
REQ-033 rst SHALL override lock and all key activity; a key held through reset release SHALL register as a press after the full latency.
REQ-034 Reset mid-repeat SHALL abort repeating; no step SHALL occur in the reset cycle.

Verification
REQ-035 Use defaults, state=0. Up held 10 cycles after reset -> song_idx 0->1 at cycle 7, single changed strobe, no repeat.
REQ-036 From idx 7, one up press -> idx 0; from idx 0, one down press -> idx 7; changed pulses each time.
REQ-037 Up raw pulse of 3 cycles, then a 2-cycle glitch -> no index change, no strobes.
REQ-038 Down held 40 cycles from idx 0 -> idx 7 at the press step (cycle 7); repeat steps 16 cycles after the press, then every 4 cycles, ending at idx 1 after all steps before release.
REQ-039 Confirm press -> selected=1 and a one-cycle confirm_pulse; then up press -> selected=0; up and down pressed in the same cycle -> idx unchanged.
REQ-040 selected=1, then state=PLAY_MODE -> selected=0 and idx held; keys ignored; back to state 0 with confirm held -> confirm_pulse after 7 cycles.
